// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the multicycle control
//               sequencer: state encoding, instruction classes, opcode and
//               extended-opcode fields, condition codes, ALU flag bit
//               positions and write-back select encodings.
//               The optional JAL feature (macro CPU_CTRL_JAL_EN) is resolved
//               in cpu_ctrl_seq; this package always recognises the JAL
//               encoding as its own class.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_FWAIT  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MWAIT  = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CL_ALU   = 3'd0,
        CL_LOAD  = 3'd1,
        CL_STOR  = 3'd2,
        CL_BCOND = 3'd3,
        CL_JCOND = 3'd4,
        CL_JAL   = 3'd5,
        CL_ILL   = 3'd6
    } class_e;

    // Primary opcode field IR[15:12]
    localparam logic [3:0] c_OP_RTYPE = 4'h0;
    localparam logic [3:0] c_OP_ANDI  = 4'h1;
    localparam logic [3:0] c_OP_ORI   = 4'h2;
    localparam logic [3:0] c_OP_XORI  = 4'h3;
    localparam logic [3:0] c_OP_SPEC  = 4'h4;
    localparam logic [3:0] c_OP_ADDI  = 4'h5;
    localparam logic [3:0] c_OP_ADDUI = 4'h6;
    localparam logic [3:0] c_OP_ADDCI = 4'h7;
    localparam logic [3:0] c_OP_SHIFT = 4'h8;
    localparam logic [3:0] c_OP_SUBI  = 4'h9;
    localparam logic [3:0] c_OP_SUBCI = 4'hA;
    localparam logic [3:0] c_OP_CMPI  = 4'hB;
    localparam logic [3:0] c_OP_BCOND = 4'hC;
    localparam logic [3:0] c_OP_MOVI  = 4'hD;

    // Extended opcode field IR[7:4] under c_OP_SPEC
    localparam logic [3:0] c_EXT_LOAD  = 4'h0;
    localparam logic [3:0] c_EXT_STOR  = 4'h4;
    localparam logic [3:0] c_EXT_JAL   = 4'h8;
    localparam logic [3:0] c_EXT_JCOND = 4'hC;

    // Condition codes IR[11:8]
    localparam logic [3:0] c_CC_EQ = 4'd0;
    localparam logic [3:0] c_CC_NE = 4'd1;
    localparam logic [3:0] c_CC_CS = 4'd2;
    localparam logic [3:0] c_CC_CC = 4'd3;
    localparam logic [3:0] c_CC_HI = 4'd4;
    localparam logic [3:0] c_CC_LS = 4'd5;
    localparam logic [3:0] c_CC_GT = 4'd6;
    localparam logic [3:0] c_CC_LE = 4'd7;
    localparam logic [3:0] c_CC_FS = 4'd8;
    localparam logic [3:0] c_CC_FC = 4'd9;
    localparam logic [3:0] c_CC_LO = 4'd10;
    localparam logic [3:0] c_CC_HS = 4'd11;
    localparam logic [3:0] c_CC_LT = 4'd12;
    localparam logic [3:0] c_CC_GE = 4'd13;
    localparam logic [3:0] c_CC_UC = 4'd14;
    localparam logic [3:0] c_CC_NV = 4'd15;

    // Bit positions within AluFlags = {C,L,F,Z,N}
    localparam int c_FLAG_N = 0;
    localparam int c_FLAG_Z = 1;
    localparam int c_FLAG_F = 2;
    localparam int c_FLAG_L = 3;
    localparam int c_FLAG_C = 4;

    // WbSel encodings
    localparam logic [1:0] c_WB_ALU  = 2'd0;
    localparam logic [1:0] c_WB_MEM  = 2'd1;
    localparam logic [1:0] c_WB_LINK = 2'd2;

    // Classify a 16-bit instruction word. Every R-type extension is handed
    // to the ALU; I-type opcodes 0xE and 0xF have no meaning and are illegal.
    function automatic class_e decode_class(input logic [15:0] ir);
        class_e cl;
        cl = CL_ILL;
        case (ir[15:12])
            c_OP_RTYPE, c_OP_ANDI, c_OP_ORI, c_OP_XORI, c_OP_ADDI,
            c_OP_ADDUI, c_OP_ADDCI, c_OP_SHIFT, c_OP_SUBI, c_OP_SUBCI,
            c_OP_CMPI, c_OP_MOVI: cl = CL_ALU;
            c_OP_BCOND:           cl = CL_BCOND;
            c_OP_SPEC: begin
                case (ir[7:4])
                    c_EXT_LOAD:  cl = CL_LOAD;
                    c_EXT_STOR:  cl = CL_STOR;
                    c_EXT_JCOND: cl = CL_JCOND;
                    c_EXT_JAL:   cl = CL_JAL;
                    default:     cl = CL_ILL;
                endcase
            end
            default: cl = CL_ILL;
        endcase
        return cl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cpu_cond_eval
// Description : Combinational branch/jump condition evaluation.
// Ports       : i_cond  [3:0] condition code from IR[11:8]
//               i_flags [4:0] registered ALU flags {C,L,F,Z,N}
//               o_taken       condition is true
// Revision    : 1.0  initial release
// ============================================================================
module cpu_cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [4:0] i_flags,
    output logic       o_taken
);

    logic w_c, w_l, w_f, w_z, w_n;

    assign w_c = i_flags[c_FLAG_C];
    assign w_l = i_flags[c_FLAG_L];
    assign w_f = i_flags[c_FLAG_F];
    assign w_z = i_flags[c_FLAG_Z];
    assign w_n = i_flags[c_FLAG_N];

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            c_CC_EQ: o_taken = w_z;
            c_CC_NE: o_taken = !w_z;
            c_CC_CS: o_taken = w_c;
            c_CC_CC: o_taken = !w_c;
            c_CC_HI: o_taken = w_l;
            c_CC_LS: o_taken = !w_l;
            c_CC_GT: o_taken = w_n;
            c_CC_LE: o_taken = !w_n;
            c_CC_FS: o_taken = w_f;
            c_CC_FC: o_taken = !w_f;
            c_CC_LO: o_taken = !w_l && !w_z;
            c_CC_HS: o_taken = w_l || w_z;
            c_CC_LT: o_taken = !w_n && !w_z;
            c_CC_GE: o_taken = w_n || w_z;
            c_CC_UC: o_taken = 1'b1;
            c_CC_NV: o_taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_seq
// Description : Multicycle control sequencer. Owns PC and IR and steps each
//               instruction through FETCH, FWAIT, DECODE, EXEC, MWAIT, WB.
//               Optional feature macro: CPU_CTRL_JAL_EN enables JAL
//               (link write-back, jump to JumpTarget); otherwise JAL is
//               reported as an illegal instruction.
// Ports       : Clk, Rst (sync, active high), Run (fetch permit),
//               InstrIn (RAM read data), AluFlags {C,L,F,Z,N},
//               JumpTarget (Rsrc value) -> InstrAddr (PC), RdestLoc,
//               RsrcLoc, OpCode, Imm, ImmSel, RegWe, WbSel, MemRe, MemWe,
//               IllegalInstr, State (debug)
// Revision    : 1.0  initial release
// ============================================================================
module cpu_ctrl_seq
    import cpu_pkg::*;
#(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 16,
    parameter int                 MEM_LAT  = 1,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Run,
    input  logic [DATA_W-1:0] InstrIn,
    input  logic [4:0]        AluFlags,
    input  logic [ADDR_W-1:0] JumpTarget,
    output logic [ADDR_W-1:0] InstrAddr,
    output logic [3:0]        RdestLoc,
    output logic [3:0]        RsrcLoc,
    output logic [7:0]        OpCode,
    output logic [DATA_W-1:0] Imm,
    output logic              ImmSel,
    output logic              RegWe,
    output logic [1:0]        WbSel,
    output logic              MemRe,
    output logic              MemWe,
    output logic              IllegalInstr,
    output logic [2:0]        State
);

    // Wait counter runs 0..MEM_LAT-1; MEM_LAT is limited to 1..4.
    localparam logic [1:0] c_LAT_LAST = 2'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [1:0]        cnt_q, cnt_d;

    class_e            w_class_raw, w_class;
    logic              w_taken;
    logic              w_imm_zext;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_br_target;
    logic              w_exec;
    logic              w_wb;

    assign w_class_raw = decode_class(ir_q[15:0]);

`ifdef CPU_CTRL_JAL_EN
    assign w_class = w_class_raw;
`else
    assign w_class = (w_class_raw == CL_JAL) ? CL_ILL : w_class_raw;
`endif

    cpu_cond_eval u_cond (
        .i_cond  (ir_q[11:8]),
        .i_flags (AluFlags),
        .o_taken (w_taken)
    );

    // Natural-width adds give modulo 2^ADDR_W wrap in both directions.
    assign w_pc_inc    = pc_q + ADDR_W'(1);
    assign w_br_target = pc_q + {{(ADDR_W-8){ir_q[7]}}, ir_q[7:0]};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_FETCH: begin
                if (Run) begin
                    state_d = ST_FWAIT;
                    cnt_d   = '0;
                end
            end
            ST_FWAIT: begin
                if (cnt_q == c_LAT_LAST) begin
                    ir_d    = InstrIn;
                    state_d = ST_DECODE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = w_pc_inc;
                case (w_class)
                    CL_LOAD: begin
                        // PC advances only once the load completes in WB.
                        state_d = ST_MWAIT;
                        pc_d    = pc_q;
                        cnt_d   = '0;
                    end
                    CL_BCOND: if (w_taken) pc_d = w_br_target;
                    CL_JCOND: if (w_taken) pc_d = JumpTarget;
                    CL_JAL:   pc_d = JumpTarget;
                    default:  ;
                endcase
            end
            ST_MWAIT: begin
                if (cnt_q == c_LAT_LAST) begin
                    state_d = ST_WB;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_WB: begin
                pc_d    = w_pc_inc;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes decode the current state; gating with Rst keeps an aborted
    // instruction from issuing a write in the cycle reset is applied.
    assign w_exec = (state_q == ST_EXEC) && !Rst;
    assign w_wb   = (state_q == ST_WB) && !Rst;

    assign RegWe        = (w_exec && ((w_class == CL_ALU) || (w_class == CL_JAL))) || w_wb;
    assign MemRe        = w_exec && (w_class == CL_LOAD);
    assign MemWe        = w_exec && (w_class == CL_STOR);
    assign IllegalInstr = w_exec && (w_class == CL_ILL);
    assign WbSel        = w_wb ? c_WB_MEM :
                          (w_exec && (w_class == CL_JAL)) ? c_WB_LINK : c_WB_ALU;

    // Logic immediates are zero-extended, everything else sign-extended.
    assign w_imm_zext = (ir_q[15:12] == c_OP_ANDI) || (ir_q[15:12] == c_OP_ORI) ||
                        (ir_q[15:12] == c_OP_XORI);
    assign Imm        = w_imm_zext ? {{(DATA_W-8){1'b0}}, ir_q[7:0]}
                                   : {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
    assign ImmSel     = (w_class == CL_ALU) && (ir_q[15:12] != c_OP_RTYPE);

    assign InstrAddr = pc_q;
    assign RdestLoc  = ir_q[11:8];
    assign RsrcLoc   = ir_q[3:0];
    assign OpCode    = {ir_q[15:12], ir_q[7:4]};
    assign State     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_ctrl_seq
// Description : Directed self-checking bench for cpu_ctrl_seq. Each step
//               queues the expected per-cycle state/strobe pattern of one
//               instruction and pops it against the DUT cycle by cycle.
//               Expectations for JAL follow macro CPU_CTRL_JAL_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_ctrl_seq;

    localparam int          L        = 2;
    localparam logic [15:0] RST_PC   = 16'h0040;

    localparam int K_ALU  = 0;
    localparam int K_LOAD = 1;
    localparam int K_STOR = 2;
    localparam int K_NONE = 3;
    localparam int K_ILL  = 4;
    localparam int K_JAL  = 5;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Run;
    logic [15:0] InstrIn;
    logic [4:0]  AluFlags;
    logic [15:0] JumpTarget;
    logic [15:0] InstrAddr;
    logic [3:0]  RdestLoc;
    logic [3:0]  RsrcLoc;
    logic [7:0]  OpCode;
    logic [15:0] Imm;
    logic        ImmSel;
    logic        RegWe;
    logic [1:0]  WbSel;
    logic        MemRe;
    logic        MemWe;
    logic        IllegalInstr;
    logic [2:0]  State;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_pc;
    logic [8:0]  sb_q[$];

    cpu_ctrl_seq #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .MEM_LAT  (L),
        .RESET_PC (RST_PC)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Run          (Run),
        .InstrIn      (InstrIn),
        .AluFlags     (AluFlags),
        .JumpTarget   (JumpTarget),
        .InstrAddr    (InstrAddr),
        .RdestLoc     (RdestLoc),
        .RsrcLoc      (RsrcLoc),
        .OpCode       (OpCode),
        .Imm          (Imm),
        .ImmSel       (ImmSel),
        .RegWe        (RegWe),
        .WbSel        (WbSel),
        .MemRe        (MemRe),
        .MemWe        (MemWe),
        .IllegalInstr (IllegalInstr),
        .State        (State)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // {State, RegWe, MemRe, MemWe, IllegalInstr, WbSel}
    function automatic logic [8:0] rec(input logic [2:0] st, input logic [3:0] stb,
                                       input logic [1:0] wb);
        return {st, stb, wb};
    endfunction

    function automatic logic [8:0] obs_vec();
        return {State, RegWe, MemRe, MemWe, IllegalInstr, WbSel};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_instr(input int kind);
        sb_q.push_back(rec(3'd0, 4'b0000, 2'd0));
        for (int i = 0; i < L; i++) sb_q.push_back(rec(3'd1, 4'b0000, 2'd0));
        sb_q.push_back(rec(3'd2, 4'b0000, 2'd0));
        case (kind)
            K_ALU:  sb_q.push_back(rec(3'd3, 4'b1000, 2'd0));
            K_LOAD: sb_q.push_back(rec(3'd3, 4'b0100, 2'd0));
            K_STOR: sb_q.push_back(rec(3'd3, 4'b0010, 2'd0));
            K_ILL:  sb_q.push_back(rec(3'd3, 4'b0001, 2'd0));
            K_JAL:  sb_q.push_back(rec(3'd3, 4'b1000, 2'd2));
            default: sb_q.push_back(rec(3'd3, 4'b0000, 2'd0));
        endcase
        if (kind == K_LOAD) begin
            for (int i = 0; i < L; i++) sb_q.push_back(rec(3'd4, 4'b0000, 2'd0));
            sb_q.push_back(rec(3'd5, 4'b1000, 2'd1));
        end
    endtask

    // Entered at a falling edge with the DUT in FETCH; leaves at the
    // falling edge where the next FETCH is visible.
    task automatic exec(input string tag, input logic [15:0] instr, input logic [4:0] flags,
                        input logic [15:0] jt, input int kind, input logic [16:0] exp_imm,
                        input logic [15:0] next_pc);
        logic [8:0] e;
        int         n;
        chk({tag, "/addr"}, 32'(InstrAddr), 32'(exp_pc));
        InstrIn    = instr;
        AluFlags   = flags;
        JumpTarget = jt;
        push_instr(kind);
        n = sb_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge Clk);
            e = sb_q.pop_front();
            chk($sformatf("%s/cyc%0d", tag, i), 32'(obs_vec()), 32'(e));
            if (e[8:6] == 3'd2) begin
                chk({tag, "/fields"}, 32'({RdestLoc, RsrcLoc, OpCode}),
                    32'({instr[11:8], instr[3:0], instr[15:12], instr[7:4]}));
                chk({tag, "/imm"}, 32'({ImmSel, Imm}), 32'(exp_imm));
            end
        end
        @(negedge Clk);
        exp_pc = next_pc;
    endtask

    initial begin
        Rst        = 1'b1;
        Run        = 1'b1;
        InstrIn    = 16'h0000;
        AluFlags   = 5'b00000;
        JumpTarget = 16'h0000;
        exp_pc     = RST_PC;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("reset/vec", 32'(obs_vec()), 32'(rec(3'd0, 4'b0000, 2'd0)));
        chk("reset/pc", 32'(InstrAddr), 32'(RST_PC));
        chk("reset/ir", 32'({RdestLoc, RsrcLoc, OpCode, ImmSel}), 32'd0);
        Rst = 1'b0;

        exec("add",   16'h0152, 5'b00000, 16'h0000, K_ALU,  {1'b0, 16'h0052}, 16'h0041);
        exec("load",  16'h4304, 5'b00000, 16'h0000, K_LOAD, {1'b0, 16'h0004}, 16'h0042);
        exec("stor",  16'h4344, 5'b00000, 16'h0000, K_STOR, {1'b0, 16'h0044}, 16'h0043);
        exec("andi",  16'h13F0, 5'b00000, 16'h0000, K_ALU,  {1'b1, 16'h00F0}, 16'h0044);
        exec("addi",  16'h53F0, 5'b00000, 16'h0000, K_ALU,  {1'b1, 16'hFFF0}, 16'h0045);

        // Run low: sequencer parks in FETCH with PC held.
        Run = 1'b0;
        for (int i = 0; i < 10; i++) sb_q.push_back(rec(3'd0, 4'b0000, 2'd0));
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk($sformatf("halt/cyc%0d", i), 32'(obs_vec()), 32'(sb_q.pop_front()));
            chk($sformatf("halt/pc%0d", i), 32'(InstrAddr), 32'(exp_pc));
        end
        Run = 1'b1;

        exec("illF",  16'hF0F0, 5'b00000, 16'h0000, K_ILL,  {1'b0, 16'hFFF0}, 16'h0046);
        exec("bne_n", 16'hC105, 5'b00010, 16'h0000, K_NONE, {1'b0, 16'h0005}, 16'h0047);
        exec("bhi_t", 16'hC403, 5'b01000, 16'h0000, K_NONE, {1'b0, 16'h0003}, 16'h004A);
        exec("juc",   16'h4EC5, 5'b00000, 16'h0001, K_NONE, {1'b0, 16'hFFC5}, 16'h0001);
        exec("beq_n", 16'hC0FE, 5'b00000, 16'h0000, K_NONE, {1'b0, 16'hFFFE}, 16'h0002);
        exec("jeq_t", 16'h40C5, 5'b00010, 16'h0001, K_NONE, {1'b0, 16'hFFC5}, 16'h0001);
        exec("beq_t", 16'hC0FE, 5'b00010, 16'h0000, K_NONE, {1'b0, 16'hFFFE}, 16'hFFFF);
        exec("wrap",  16'h0152, 5'b00000, 16'h0000, K_ALU,  {1'b0, 16'h0052}, 16'h0000);
        exec("jnv",   16'h4FC5, 5'b11111, 16'h1234, K_NONE, {1'b0, 16'hFFC5}, 16'h0001);
`ifdef CPU_CTRL_JAL_EN
        exec("jal",   16'h4584, 5'b00000, 16'h1234, K_JAL,  {1'b0, 16'hFF84}, 16'h1234);
`else
        exec("jal",   16'h4584, 5'b00000, 16'h1234, K_ILL,  {1'b0, 16'hFF84}, 16'h0002);
`endif
        exec("ill4",  16'h4010, 5'b00000, 16'h0000, K_ILL,  {1'b0, 16'h0010}, exp_pc + 16'h0001);

        // Reset applied while a load sits in EXEC aborts it silently.
        chk("abort/addr", 32'(InstrAddr), 32'(exp_pc));
        InstrIn = 16'h4304;
        repeat (L + 2) @(negedge Clk);
        chk("abort/exec", 32'(obs_vec()), 32'(rec(3'd3, 4'b0100, 2'd0)));
        Rst = 1'b1;
        #1;
        chk("abort/rstcyc", 32'({RegWe, MemRe, MemWe, IllegalInstr, WbSel}), 32'd0);
        @(negedge Clk);
        chk("abort/after", 32'(obs_vec()), 32'(rec(3'd0, 4'b0000, 2'd0)));
        chk("abort/pc", 32'(InstrAddr), 32'(RST_PC));
        Rst = 1'b0;
        Run = 1'b0;
        @(negedge Clk);
        chk("abort/idle", 32'(obs_vec()), 32'(rec(3'd0, 4'b0000, 2'd0)));
        chk("abort/pc2", 32'(InstrAddr), 32'(RST_PC));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_ctrl_seq.md
# cpu_ctrl_seq

Parametrised multicycle control sequencer that replaces the separate CPU FSM and program counter inside the CPU top level. Owns the PC and the instruction register, and sequences each 16-bit CR16-style instruction through fetch, decode, execute, memory and writeback. Drives the register file/ALU and the dual-port RAM control pins. Generalises the earlier controller with configurable address width, RAM read latency, an external run/halt input, conditional branches/jumps and illegal-opcode reporting.

## Interface
- DATA_W, 16, instruction/immediate width (fixed ISA encoding uses bits [15:0])
- ADDR_W, 16, PC / instruction address width
- MEM_LAT, 1, RAM read latency in cycles, legal 1..4
- RESET_PC, 0, PC value loaded on reset
- Clk  in  1  system clock, all state on rising edge
- Rst  in  1  synchronous, active-high reset
- Run  in  1  high permits a new fetch; low holds in FETCH
- InstrIn  in  DATA_W  RAM read data (instruction or load data)
- AluFlags  in  5  {C,L,F,Z,N} registered flags from ALU
- JumpTarget  in  ADDR_W  Rsrc register value for Jcond/JAL
- InstrAddr  out  ADDR_W  current PC to RAM port A
- RdestLoc, RsrcLoc  out  4  register file addresses, IR[11:8], IR[3:0]
- OpCode  out  8  {IR[15:12], IR[7:4]} to ALU
- Imm  out  DATA_W  sign- or zero-extended IR[7:0]
- ImmSel  out  1  ALU B operand = Imm
- RegWe  out  1  register write strobe
- WbSel  out  2  0 ALU, 1 memory data, 2 link (PC+1)
- MemRe, MemWe  out  1  data-memory read/write strobes (address = Rsrc value)
- IllegalInstr  out  1  one-cycle pulse on undecodable instruction
- State  out  3  current state encoding, debug

## Operation
- States: FETCH(0), FWAIT(1), DECODE(2), EXEC(3), MWAIT(4), WB(5).
- FETCH: InstrAddr=PC; if Run -> FWAIT else stay.
- FWAIT: counts MEM_LAT cycles; on last, IR<=InstrIn, -> DECODE.
- DECODE: drive RdestLoc/RsrcLoc/OpCode/Imm/ImmSel from IR; -> EXEC.
- EXEC by class:
  - R-type (IR[15:12]=0000), I-type (other ALU opcodes): RegWe=1, WbSel=0, PC<=PC+1, -> FETCH.
  - LOAD (0100/0000): MemRe=1, -> MWAIT; STOR (0100/0100): MemWe=1, PC<=PC+1, -> FETCH.
  - Bcond (1100): cond=IR[11:8]; if true PC<=PC+sext(IR[7:0]) else PC+1; -> FETCH.
  - Jcond (0100/1100): cond=IR[11:8]; if true PC<=JumpTarget else PC+1; -> FETCH.
  - Undefined: IllegalInstr=1, no strobes, PC<=PC+1, -> FETCH.
- MWAIT: MEM_LAT cycles -> WB. WB: RegWe=1, WbSel=1, PC<=PC+1, -> FETCH.
- Conditions: EQ Z, NE !Z, CS C, CC !C, HI L, LS !L, GT N, LE !N, FS F, FC !F, LO !L&!Z, HS L|Z, LT !N&!Z, GE N|Z, UC 1, NV 0.
- Imm: zero-extended for logic ops (AND/OR/XOR), sign-extended otherwise.
- PC arithmetic modulo 2^ADDR_W; wrap from all-ones to 0 and negative branch past 0 required.
- Strobes are combinational on state, asserted exactly one cycle per instruction.

## Timing
- Reset: state FETCH, PC=RESET_PC, IR=0, all strobes/IllegalInstr 0, WbSel 0, State 0.
- Reset mid-instruction aborts it; no strobe in the reset cycle or the one after.
- ALU/store/branch instruction: 3+MEM_LAT cycles; load: 4+2*MEM_LAT.
- Run sampled only in FETCH; deassertion mid-instruction completes current instruction.
- RAM data sampled in last FWAIT / MWAIT cycle.

## Configuration
- CPU_CTRL_JAL_EN defined: JAL (0100/1000) in EXEC: RegWe=1, WbSel=2, PC<=JumpTarget.
- Undefined: JAL decodes as illegal (IllegalInstr pulse, PC+1); WbSel never 2.

## Structure
- Package cpu_pkg: state enum, opcode/ext constants, condition codes, flag bit indices, WbSel encodings.
- Sub-module cpu_cond_eval: combinational condition evaluation (cond, flags -> taken).

## Test plan
- Reset with RESET_PC=16'h0040, Run=1 -> InstrAddr=0040, FWAIT after 1 cycle, all strobes 0.
- ADD R1,R2 (16'h0152), MEM_LAT=2 -> RegWe one cycle in cycle 5, PC=0041.
- LOAD R3,[R4] (16'h4304), MEM_LAT=1 -> MemRe cycle 4, RegWe/WbSel=1 cycle 6, PC+1.
- BEQ disp -2 (16'hC0FE), Z=1 at PC=0001 -> PC=FFFF; Z=0 -> PC=0002.
- Run=0 for 10 cycles in FETCH -> State=0, PC unchanged, no strobes; opcode 16'hF0F0 -> IllegalInstr pulse, PC+1.
- JAL (16'h4584), JumpTarget=1234 -> with CPU_CTRL_JAL_EN RegWe, WbSel=2, PC=1234; without, IllegalInstr.
